// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU
// among NREQ requesters using valid/ready request and response channels.
module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*4-1:0]    req_sel,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [XLEN-1:0]      resp_data,
  output logic                 resp_err,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [3:0]           alu_sel,
  input  logic [XLEN-1:0]      alu_result,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] SEL_MAX = 4'd9;

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [3:0]      sel_q, sel_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;
  logic [XLEN-1:0] win_a;
  logic [XLEN-1:0] win_b;
  logic [3:0]      win_sel;
  logic            accept;
  logic            sel_legal;
  logic            in_idle;
  logic            in_exec;
  logic            in_resp;
  logic [PW-1:0]   next_ptr;

  assign in_idle   = (state_q == S_IDLE);
  assign in_exec   = (state_q == S_EXEC);
  assign in_resp   = (state_q == S_RESP);
  assign sel_legal = (sel_q <= SEL_MAX);

  assign next_ptr = (owner_q == PW'(NREQ - 1))
                  ? '0
                  : owner_q + PW'(1);

  // Winner: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(rr_ptr_q) + i) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_a   = req_a[win_idx*XLEN +: XLEN];
  assign win_b   = req_b[win_idx*XLEN +: XLEN];
  assign win_sel = req_sel[win_idx*4 +: 4];

  // Grant only the winner, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && in_idle && win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  // Next-state and datapath capture.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    err_d       = err_q;
    resp_data_d = resp_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = win_a;
          b_d     = win_b;
          sel_d   = win_sel;
          owner_d = win_idx;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        resp_data_d = sel_legal ? alu_result : '0;
        err_d       = !sel_legal;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (resp_ready[owner_q]) begin
          rr_ptr_d = next_ptr;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      resp_data_q <= resp_data_d;
    end
  end

  // ALU is driven only in EXEC; illegal selects become ADD.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (in_exec) begin
      alu_a   = a_q;
      alu_b   = b_q;
      alu_sel = sel_legal ? sel_q : 4'd0;
    end
  end

  // Response valid goes only to the owner.
  always_comb begin
    resp_valid = '0;
    if (in_resp) begin
      resp_valid[owner_q] = 1'b1;
    end
  end

  assign resp_err  = in_resp & err_q;
  assign resp_data = resp_data_q;
  assign busy      = !in_idle;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench with a reference
// arbitration model and a behavioural ALU.
module tb_alu_share_arbiter;

  localparam int NREQ = 2;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic            v [NREQ];
  logic [XLEN-1:0] av[NREQ];
  logic [XLEN-1:0] bv[NREQ];
  logic [3:0]      sv[NREQ];
  logic            rr[NREQ];
  bit              rand_rr = 1'b0;

  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ-1:0]      resp_valid, resp_ready;
  logic [NREQ*XLEN-1:0] req_a, req_b;
  logic [NREQ*4-1:0]    req_sel;
  logic [XLEN-1:0]      resp_data, alu_a, alu_b, alu_result;
  logic [3:0]           alu_sel;
  logic                 resp_err, busy;

  for (genvar g = 0; g < NREQ; g++) begin : g_pk
    assign req_valid[g]              = v[g];
    assign req_a[g*XLEN +: XLEN]     = av[g];
    assign req_b[g*XLEN +: XLEN]     = bv[g];
    assign req_sel[g*4 +: 4]         = sv[g];
    assign resp_ready[g]             = rr[g];
  end

  alu_share_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .busy(busy)
  );

  function automatic logic [31:0] alu_fn(
    input logic [31:0] a, input logic [31:0] b,
    input logic [3:0] s);
    case (s)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return {31'b0, $signed(a) < $signed(b)};
      4'd3: return {31'b0, a < b};
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return 32'($signed(a) >>> b[4:0]);
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_sel);

  typedef struct {
    int          owner;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  exp_t done_q[$];
  int   gq[$];
  int   m_ptr = 0;
  int   m_phase = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor and reference model, sampled on the falling edge.
  initial begin
    exp_t            e;
    logic [NREQ-1:0] er;
    logic [NREQ-1:0] oh;
    bit              found;
    int              j;
    int              jw;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_alu", (|alu_a) | (|alu_b) | (|alu_sel), 0);
        sbq.delete();
        m_ptr = 0;
        m_phase = 0;
      end else begin
        er = '0;
        found = 1'b0;
        jw = 0;
        if (m_phase == 0) begin
          for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (!found && req_valid[j]) begin
              found = 1'b1;
              er[j] = 1'b1;
              jw = j;
            end
          end
        end
        chk("req_ready", req_ready, er);
        chk("busy", busy, m_phase != 0);
        if (m_phase == 1 && sbq.size() > 0) begin
          e = sbq[0];
          chk("exec_alu_a", alu_a, e.a);
          chk("exec_alu_b", alu_b, e.b);
          chk("exec_alu_sel", alu_sel,
              (e.sel > 4'd9) ? 4'd0 : e.sel);
        end else begin
          chk("alu_quiet", (|alu_a) | (|alu_b) | (|alu_sel), 0);
        end
        if (m_phase == 2 && sbq.size() > 0) begin
          e = sbq[0];
          oh = '0;
          oh[e.owner] = 1'b1;
          chk("resp_valid", resp_valid, oh);
          chk("resp_data", resp_data, e.data);
          chk("resp_err", resp_err, e.err);
          if (rr[e.owner]) begin
            void'(sbq.pop_front());
            done_q.push_back(e);
            m_ptr = (e.owner + 1) % NREQ;
            m_phase = 0;
          end
        end else begin
          chk("resp_valid_idle", resp_valid, 0);
          chk("resp_err_idle", resp_err, 0);
          if (m_phase == 1) begin
            m_phase = 2;
          end else if (m_phase == 0 && found) begin
            e.owner = jw;
            e.a     = av[jw];
            e.b     = bv[jw];
            e.sel   = sv[jw];
            e.err   = (sv[jw] > 4'd9);
            e.data  = e.err ? 32'd0 : alu_fn(av[jw], bv[jw], sv[jw]);
            sbq.push_back(e);
            gq.push_back(jw);
            m_phase = 1;
          end
        end
      end
    end
  end

  // Random response backpressure when enabled.
  initial begin
    forever begin
      step();
      if (rand_rr) begin
        for (int i = 0; i < NREQ; i++) rr[i] = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic issue(input int i,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [3:0] s,
                       input bit immediate);
    int w;
    v[i] = 1'b1;
    av[i] = a;
    bv[i] = b;
    sv[i] = s;
    w = 0;
    @(negedge clk);
    while (!req_ready[i] && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (w >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout r%0d: got no grant required grant",
               i);
      v[i] = 1'b0;
    end else begin
      if (immediate) chk("grant_immediate", w, 0);
      step();
      v[i] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (busy && w < 100);
    if (w >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy required idle");
    end
    step();
  endtask

  task automatic rand_req(input int i);
    logic [31:0] a;
    logic [31:0] b;
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) step();
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40))
                                      : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40))
                                      : $urandom;
      issue(i, a, b, 4'($urandom_range(0, 11)), 1'b0);
    end
  endtask

  initial begin
    int nd;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b0;
      av[i] = '0;
      bv[i] = '0;
      sv[i] = '0;
      rr[i] = 1'b1;
    end
    #2 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    issue(0, 32'd5, 32'd7, 4'd0, 1'b1);
    wait_idle();
    chk("single_data", done_q[$].data, 12);
    chk("single_err", done_q[$].err, 0);

    issue(1, $urandom, $urandom, 4'd4, 1'b1);
    wait_idle();
    issue(1, $urandom, $urandom, 4'd7, 1'b1);
    wait_idle();

    issue(1, $urandom, $urandom, 4'hC, 1'b1);
    wait_idle();
    chk("illegal_data", done_q[$].data, 0);
    chk("illegal_err", done_q[$].err, 1);

    gq.delete();
    done_q.delete();
    fork
      begin
        repeat (3) issue(0, 32'd10, 32'd3, 4'd1, 1'b0);
      end
      begin
        repeat (3) issue(1, 32'd1, 32'hFFFF_FFFF, 4'd3, 1'b0);
      end
    join
    wait_idle();
    chk("fair_count", gq.size(), 6);
    chk("cont_count", done_q.size(), 6);
    for (int k = 0; k < 6 && k < gq.size() && k < done_q.size(); k++) begin
      chk("fair_grant", gq[k], k % 2);
      chk("cont_owner", done_q[k].owner, k % 2);
      chk("cont_data", done_q[k].data, (k % 2) ? 1 : 7);
    end

    gq.delete();
    rr[1] = 1'b0;
    fork
      issue(1, $urandom, $urandom, 4'd0, 1'b1);
      begin
        step();
        step();
        issue(0, $urandom, $urandom, 4'd9, 1'b0);
      end
      begin
        repeat (8) step();
        rr[1] = 1'b1;
      end
    join
    wait_idle();
    chk("bp_count", gq.size(), 2);
    if (gq.size() == 2) begin
      chk("bp_first", gq[0], 1);
      chk("bp_second", gq[1], 0);
    end

    rr[0] = 1'b0;
    nd = done_q.size();
    issue(0, 32'd100, 32'd23, 4'd0, 1'b1);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_resp_valid", resp_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_req_ready", req_ready, 0);
    chk("async_resp_data", resp_data, 0);
    step();
    step();
    rr[0] = 1'b1;
    rst_n = 1'b1;
    step();
    issue(1, 32'd8, 32'd2, 4'd1, 1'b1);
    wait_idle();
    chk("rst_done_count", done_q.size(), nd + 1);
    chk("rst_after_owner", done_q[$].owner, 1);
    chk("rst_after_data", done_q[$].data, 6);

    rand_rr = 1'b1;
    fork
      rand_req(0);
      rand_req(1);
    join
    rand_rr = 1'b0;
    step();
    for (int i = 0; i < NREQ; i++) rr[i] = 1'b1;
    wait_idle();
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
